// File: rtl/cdb_arbiter.sv
// cdb_arbiter: buffers functional-unit results per port and broadcasts one per cycle on the CDB.
// Latency: one cycle from FIFO head to registered Cdb_* outputs; no same-cycle bypass.
// Backpressure: fu_ready[i] drops while FIFO i holds DEPTH entries; flush discards all buffered results.

// Generic FIFO with pointer wrap modulo DEPTH and a synchronous clear.
module cdb_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clear,
  input  logic         push,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic [W-1:0] head_dat,
  output logic         ready,
  output logic         not_empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  // ready comes from the registered count only, so a same-cycle pop never raises it
  assign ready     = (count < CNT_FULL);
  assign not_empty = (count != '0);
  assign do_push   = push && !clear && ready;
  assign do_pop    = pop && !clear && not_empty;
  assign head_dat  = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; clear empties the FIFO in one edge
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (!do_push && do_pop) count <= count - 1'b1;
    end
  end

  // Entry storage; contents are meaningless outside the occupied window so no reset
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module cdb_arbiter #(
  parameter int NUM_FU = 4,
  parameter int DEPTH  = 2,
  parameter int TAG_W  = 5
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic [NUM_FU-1:0]   fu_valid,
  output logic [NUM_FU-1:0]   fu_ready,
  input  logic [NUM_FU*TAG_W-1:0] fu_tag,
  input  logic [NUM_FU*32-1:0]    fu_data,
  input  logic [NUM_FU-1:0]   fu_branch,
  input  logic [NUM_FU-1:0]   fu_taken,
  output logic [TAG_W-1:0]    Cdb_rd_tag,
  output logic                Cdb_valid,
  output logic [31:0]         Cdb_data,
  output logic                Cdb_branch,
  output logic                Cdb_branch_taken
);
  localparam int IDX_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  typedef struct packed {
    logic [TAG_W-1:0] tag;
    logic [31:0]      data;
    logic             branch;
    logic             taken;
  } cdb_ent_t;

  localparam int ENT_W = $bits(cdb_ent_t);

  cdb_ent_t          head [NUM_FU];
  logic [NUM_FU-1:0] push;
  logic [NUM_FU-1:0] pop;
  logic [NUM_FU-1:0] not_empty;
  logic [IDX_W-1:0]  last_grant;
  logic [IDX_W-1:0]  grant_idx;
  logic [IDX_W-1:0]  cand;
  logic              grant_vld;

  for (genvar i = 0; i < NUM_FU; i++) begin : g_port
    cdb_ent_t in_ent;
    assign in_ent = '{tag:    fu_tag[i*TAG_W +: TAG_W],
                      data:   fu_data[i*32 +: 32],
                      branch: fu_branch[i],
                      taken:  fu_taken[i]};
    assign push[i] = fu_valid[i] && fu_ready[i] && !flush;

    cdb_fifo #(.W(ENT_W), .DEPTH(DEPTH)) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .clear     (flush),
      .push      (push[i]),
      .push_dat  (in_ent),
      .pop       (pop[i]),
      .head_dat  (head[i]),
      .ready     (fu_ready[i]),
      .not_empty (not_empty[i])
    );
  end

  // Round-robin pick of the first non-empty FIFO after last_grant; flush suppresses the grant
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_grant;
    cand      = last_grant;
    pop       = '0;
    for (int k = 1; k <= NUM_FU; k++) begin
      cand = IDX_W'((int'(last_grant) + k) % NUM_FU);
      if (!grant_vld && not_empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
    if (flush) grant_vld = 1'b0;
    pop[grant_idx] = grant_vld;
  end

  // Priority pointer moves only when a grant is actually made
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         last_grant <= IDX_W'(NUM_FU - 1);
    else if (grant_vld) last_grant <= grant_idx;
  end

  // Broadcast register: payload holds when idle, taken is masked for non-branches
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      Cdb_valid        <= 1'b0;
      Cdb_rd_tag       <= '0;
      Cdb_data         <= '0;
      Cdb_branch       <= 1'b0;
      Cdb_branch_taken <= 1'b0;
    end else if (grant_vld) begin
      Cdb_valid        <= 1'b1;
      Cdb_rd_tag       <= head[grant_idx].tag;
      Cdb_data         <= head[grant_idx].data;
      Cdb_branch       <= head[grant_idx].branch;
      Cdb_branch_taken <= head[grant_idx].taken & head[grant_idx].branch;
    end else begin
      Cdb_valid        <= 1'b0;
    end
  end
endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter NUM_FU, default 4: number of functional-unit result ports (0=ALU, 1=MUL, 2=MEM, 3=BR).
REQ-002 SHALL have parameter DEPTH, default 2: per-port result buffer entries.
REQ-003 SHALL have parameter TAG_W, default 5: tag width, matching the ROB tag space.
REQ-004 SHALL have a single clock; reset is asynchronous and active-low.
REQ-005 SHALL have the following ports, one per line:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  ROB flush (misprediction) request.
- fu_valid  in  NUM_FU  per-port result offer.
- fu_ready  out  NUM_FU  per-port buffer not full.
- fu_tag  in  NUM_FU*TAG_W  per-port destination tag; port i occupies bits [i*TAG_W +: TAG_W].
- fu_data  in  NUM_FU*32  per-port result; port i occupies bits [i*32 +: 32].
- fu_branch  in  NUM_FU  result is a branch.
- fu_taken  in  NUM_FU  branch must be taken.
- Cdb_rd_tag  out  TAG_W  broadcast tag.
- Cdb_valid  out  1  broadcast valid, one cycle per result.
- Cdb_data  out  32  broadcast data.
- Cdb_branch  out  1  broadcast is a branch.
- Cdb_branch_taken  out  1  branch taken; qualified by Cdb_valid.

Function
REQ-006 Port i SHALL accept a result on a rising edge where fu_valid[i] && fu_ready[i] && !flush.
- An accepted entry {tag, data, branch, taken} is pushed into FIFO i.
REQ-007 fu_ready[i] SHALL equal (count[i] < DEPTH), derived from the registered count only.
- A same-cycle pop does not raise fu_ready.
REQ-008 Each FIFO SHALL use read/write pointers that wrap modulo DEPTH, plus a count of width clog2(DEPTH+1).
- Simultaneous push and pop leaves count unchanged.
REQ-009 Each cycle the arbiter SHALL grant at most one non-empty FIFO, in round-robin order.
- Search starts at index (last_grant+1) mod NUM_FU.
- last_grant updates only on a grant.
- last_grant resets to NUM_FU-1, so port 0 wins first.
REQ-010 On a grant to port g, at the next rising edge the block SHALL:
- pop FIFO g;
- register its head entry onto Cdb_rd_tag, Cdb_data, Cdb_branch, Cdb_branch_taken;
- set Cdb_valid=1.
REQ-011 With no grant, Cdb_valid SHALL be 0 next cycle; the other Cdb_* outputs hold their last values.
REQ-012 Latency SHALL be exactly one cycle.
- A result accepted at edge N into an empty FIFO, with no competing heads, is broadcast with Cdb_valid=1 during the cycle after edge N+1.
REQ-013 A result accepted into an empty FIFO SHALL NOT be granted in the same cycle it is accepted; there is no bypass.
REQ-014 Throughput SHALL be one broadcast per cycle sustained while any FIFO is non-empty.
- No FIFO may wait more than NUM_FU-1 grants.
REQ-015 When flush=1 at a rising edge, the block SHALL:
- clear all FIFO counts and pointers;
- drive Cdb_valid=0 next cycle;
- reject all fu_valid inputs that cycle;
- make no grant.
- last_grant is unchanged.
REQ-016 The registered Cdb_branch_taken SHALL equal head.taken && head.branch, so non-branch results never assert taken.
REQ-017 While the block is idle with all FIFOs empty, no state SHALL change except Cdb_valid=0.

Reset
REQ-018 While reset=0, all outputs SHALL take these values asynchronously:
- Cdb_valid=0, Cdb_rd_tag=0, Cdb_data=0, Cdb_branch=0, Cdb_branch_taken=0;
- fu_ready all 1 after the FIFOs clear.
REQ-019 Reset SHALL clear all FIFOs and set last_grant=NUM_FU-1.
- Reset asserted mid-operation discards buffered results; none are broadcast after release.
REQ-020 Deassertion SHALL be synchronous to clock; the first accept is allowed at the first rising edge with reset=1.

Verification
REQ-021 The bench SHALL cover the following scenarios:
- Single result: port 1 offers tag 7, data 0x0000_00AB at edge 1 -> Cdb_valid=1, Cdb_rd_tag=7, Cdb_data=0xAB after edge 2, then Cdb_valid=0 after edge 3.
- Round robin: all four ports offer tags 1,2,3,4 in the same cycle -> broadcasts in order 1,2,3,4 on four consecutive cycles, with no gaps.
- Full/backpressure: port 0 offers tags 10,11,12 back-to-back while port 3 holds priority -> fu_ready[0]=0 after two accepts; tag 12 is accepted only after a pop, and all three are broadcast in order.
- Branch: port 3 offers branch=1, taken=1, tag 9 -> Cdb_branch=1, Cdb_branch_taken=1. Port 0 offers branch=0, taken=1 -> Cdb_branch_taken=0.
- Flush: three entries buffered, flush pulsed for one cycle with port 2 offering -> no Cdb_valid afterwards, port 2 entry dropped, all fu_ready=1.
- Async reset: reset dropped mid-cycle with FIFOs non-empty -> Cdb_valid falls immediately, no broadcasts after release.
